// File: rtl/circ_buf_seq_if.sv
// Sample-side bundle of circ_buf_seq: write strobe/data in, tap read-out and status out.
// state_dbg mirrors the sequencer FSM (0 = IDLE, 1 = SEQ) for observation only.
interface circ_buf_seq_if #(
   parameter int WIDTH = 16
);
   logic             wrt_smpl;
   logic [WIDTH-1:0] smpl_in;
   logic [WIDTH-1:0] smpl_out;
   logic             smpl_vld;
   logic             sequencing;
   logic             full;
   logic             ovr;
   logic             state_dbg;

   // Strobe semantics, no back-pressure: wrt_smpl writes smpl_in in that one cycle;
   // smpl_vld marks smpl_out as a burst sample in that one cycle.
   modport master (
      output wrt_smpl, smpl_in,
      input  smpl_out, smpl_vld, sequencing, full, ovr, state_dbg
   );

   modport slave (
      input  wrt_smpl, smpl_in,
      output smpl_out, smpl_vld, sequencing, full, ovr, state_dbg
   );
endinterface

// File: rtl/circ_buf_seq.sv
// Circular sample buffer that bursts the latest TAPS samples (oldest first) after each new sample.
// Optional macro OVR_DET_EN adds a sticky overrun flag for writes arriving mid-burst.
module circ_buf_seq #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1536,
   parameter int TAPS  = 1021
) (
   input  logic          clk,
   input  logic          rst_n,
   circ_buf_seq_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(TAPS + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEQ  = 1'b1;

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   BACK_X   = (AW+1)'(TAPS - 1);
   localparam logic [CW-1:0] TAPS_C   = CW'(TAPS);
   localparam logic [CW-1:0] TAPS_M1  = CW'(TAPS - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    new_ptr_q, new_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    tap_cnt_q, tap_cnt_d;
   logic [0:0]       state_q, state_d;
   logic             full_q, full_d;
   logic             smpl_vld_q, smpl_vld_d;
   logic [WIDTH-1:0] smpl_out_q, smpl_out_d;
   logic             trigger;
   logic [AW:0]      back_sum;

   always_comb begin
      new_ptr_d  = new_ptr_q;
      cnt_d      = cnt_q;
      rd_ptr_d   = rd_ptr_q;
      tap_cnt_d  = tap_cnt_q;
      state_d    = state_q;
      back_sum   = {1'b0, new_ptr_q} - BACK_X;
      if ({1'b0, new_ptr_q} < BACK_X) back_sum = back_sum + DEPTH_X;

      if (bus.wrt_smpl) begin
         new_ptr_d = (new_ptr_q == PTR_LAST) ? '0 : new_ptr_q + AW'(1);
         if (cnt_q != TAPS_C) cnt_d = cnt_q + CW'(1);
      end

      // This write brings the count to TAPS (or it was already there).
      trigger = (state_q == IDLE) && bus.wrt_smpl && (cnt_d == TAPS_C);

      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d   = SEQ;
               rd_ptr_d  = back_sum[AW-1:0];
               tap_cnt_d = '0;
            end
         end
         default: begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
            if (tap_cnt_q == TAPS_M1) begin
               state_d   = IDLE;
               tap_cnt_d = '0;
            end else begin
               tap_cnt_d = tap_cnt_q + CW'(1);
            end
         end
      endcase

      full_d     = (cnt_d == TAPS_C);
      smpl_vld_d = (state_q == SEQ);
      smpl_out_d = (state_q == SEQ) ? mem[rd_ptr_q] : smpl_out_q;
   end

   // Storage is not reset; only the pointers and flags are.
   always_ff @(posedge clk) begin
      if (bus.wrt_smpl) mem[new_ptr_q] <= bus.smpl_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         new_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         tap_cnt_q  <= '0;
         state_q    <= IDLE;
         full_q     <= 1'b0;
         smpl_vld_q <= 1'b0;
         smpl_out_q <= '0;
      end else begin
         new_ptr_q  <= new_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         tap_cnt_q  <= tap_cnt_d;
         state_q    <= state_d;
         full_q     <= full_d;
         smpl_vld_q <= smpl_vld_d;
         smpl_out_q <= smpl_out_d;
      end
   end

   assign bus.smpl_out   = smpl_out_q;
   assign bus.smpl_vld   = smpl_vld_q;
   assign bus.sequencing = (state_q == SEQ);
   assign bus.full       = full_q;
   assign bus.state_dbg  = state_q[0];

`ifdef OVR_DET_EN
   logic ovr_q, ovr_d;

   // A write mid-burst sets the flag; the next write seen in IDLE clears it.
   always_comb begin
      ovr_d = ovr_q;
      if (bus.wrt_smpl) ovr_d = (state_q == SEQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovr_q <= 1'b0;
      else        ovr_q <= ovr_d;
   end

   assign bus.ovr = ovr_q;
`else
   assign bus.ovr = 1'b0;
`endif
endmodule

// File: tb/tb_circ_buf_seq.sv
// Directed bench for circ_buf_seq: three instances cover DEPTH=8/TAPS=5, DEPTH=6/TAPS=6, DEPTH=8/TAPS=1.
`timescale 1ns/1ps
module tb_circ_buf_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   sel = 0;

   logic        seq_m, vld_m, full_m, ovr_m;
   logic [15:0] out_m;
   logic [15:0] exp_b [8];
   logic        ovr_exp;

   circ_buf_seq_if #(.WIDTH(16)) b0 ();
   circ_buf_seq_if #(.WIDTH(16)) b1 ();
   circ_buf_seq_if #(.WIDTH(16)) b2 ();

   circ_buf_seq #(.WIDTH(16), .DEPTH(8), .TAPS(5)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   circ_buf_seq #(.WIDTH(16), .DEPTH(6), .TAPS(6)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   circ_buf_seq #(.WIDTH(16), .DEPTH(8), .TAPS(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

   always #5 clk = ~clk;

   always_comb begin
      case (sel)
         1: begin
            seq_m = b1.sequencing; vld_m = b1.smpl_vld; full_m = b1.full;
            ovr_m = b1.ovr; out_m = b1.smpl_out;
         end
         2: begin
            seq_m = b2.sequencing; vld_m = b2.smpl_vld; full_m = b2.full;
            ovr_m = b2.ovr; out_m = b2.smpl_out;
         end
         default: begin
            seq_m = b0.sequencing; vld_m = b0.smpl_vld; full_m = b0.full;
            ovr_m = b0.ovr; out_m = b0.smpl_out;
         end
      endcase
   end

`ifdef OVR_DET_EN
   assign ovr_exp = 1'b1;
`else
   assign ovr_exp = 1'b0;
`endif

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [15:0] v);
      case (sel)
         1:       begin b1.wrt_smpl = w; b1.smpl_in = v; end
         2:       begin b2.wrt_smpl = w; b2.smpl_in = v; end
         default: begin b0.wrt_smpl = w; b0.smpl_in = v; end
      endcase
   endtask

   // Called at a negedge; the write is taken at the next posedge (cycle T), returns in T+1.
   task automatic wr(input logic [15:0] v);
      drive(1'b1, v);
      @(negedge clk);
      drive(1'b0, 16'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Entered in cycle T+1 of a triggering write; checks the whole burst against exp_b.
   task automatic burst_arr(input int taps);
      for (int k = 1; k <= taps + 1; k++) begin
         chk("seq", {15'h0, seq_m}, 16'(k <= taps));
         chk("vld", {15'h0, vld_m}, 16'(k >= 2));
         if (k >= 2) chk("out", out_m, exp_b[k-2]);
         @(negedge clk);
      end
      chk("vld_end", {15'h0, vld_m}, 16'h0);
      chk("seq_end", {15'h0, seq_m}, 16'h0);
   endtask

   task automatic burst(input int taps, input int first);
      for (int i = 0; i < taps; i++) exp_b[i] = 16'(first + i);
      burst_arr(taps);
   endtask

   initial begin
      b0.wrt_smpl = 1'b0; b0.smpl_in = '0;
      b1.wrt_smpl = 1'b0; b1.smpl_in = '0;
      b2.wrt_smpl = 1'b0; b2.smpl_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_seq", {15'h0, b0.sequencing}, 16'h0);
      chk("rst_vld", {15'h0, b0.smpl_vld}, 16'h0);
      chk("rst_full", {15'h0, b0.full}, 16'h0);
      chk("rst_ovr", {15'h0, b0.ovr}, 16'h0);
      chk("rst_out", b0.smpl_out, 16'h0);
      rst_n = 1'b1;
      idle(2);

      // Fill: four samples do not start a burst, the fifth does.
      sel = 0;
      for (int v = 1; v <= 4; v++) begin
         wr(16'(v));
         chk("fill_seq", {15'h0, seq_m}, 16'h0);
         chk("fill_full", {15'h0, full_m}, 16'h0);
         idle(9);
         chk("fill_seq_late", {15'h0, seq_m}, 16'h0);
      end
      wr(16'd5);
      chk("full_rise", {15'h0, full_m}, 16'h1);
      burst(5, 1);
      idle(2);

      // Wrap: every later write bursts its latest five samples.
      for (int v = 6; v <= 12; v++) begin
         wr(16'(v));
         chk("wrap_full", {15'h0, full_m}, 16'h1);
         burst(5, v - 4);
         idle(2);
      end

      // Overrun: 21 lands two cycles after 20, mid-burst.
      wr(16'd20);
      chk("ovr_t1_seq", {15'h0, seq_m}, 16'h1);
      chk("ovr_t1_vld", {15'h0, vld_m}, 16'h0);
      @(negedge clk);
      drive(1'b1, 16'd21);
      chk("ovr_t2_out", out_m, 16'd9);
      chk("ovr_t2_seq", {15'h0, seq_m}, 16'h1);
      @(negedge clk);
      drive(1'b0, 16'h0);
      chk("ovr_t3_out", out_m, 16'd10);
      chk("ovr_t3_flag", {15'h0, ovr_m}, {15'h0, ovr_exp});
      @(negedge clk);
      chk("ovr_t4_out", out_m, 16'd11);
      @(negedge clk);
      chk("ovr_t5_out", out_m, 16'd12);
      chk("ovr_t5_seq", {15'h0, seq_m}, 16'h1);
      @(negedge clk);
      chk("ovr_t6_out", out_m, 16'd20);
      chk("ovr_t6_vld", {15'h0, vld_m}, 16'h1);
      chk("ovr_t6_seq", {15'h0, seq_m}, 16'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("ovr_no_burst_seq", {15'h0, seq_m}, 16'h0);
         chk("ovr_no_burst_vld", {15'h0, vld_m}, 16'h0);
      end
      chk("ovr_hold", {15'h0, ovr_m}, {15'h0, ovr_exp});
      wr(16'd22);
      chk("ovr_clear", {15'h0, ovr_m}, 16'h0);
      exp_b[0] = 16'd11; exp_b[1] = 16'd12; exp_b[2] = 16'd20;
      exp_b[3] = 16'd21; exp_b[4] = 16'd22;
      burst_arr(5);
      idle(2);

      // Reset in the middle of a burst.
      wr(16'd23);
      idle(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_seq", {15'h0, seq_m}, 16'h0);
      chk("mid_rst_vld", {15'h0, vld_m}, 16'h0);
      chk("mid_rst_full", {15'h0, full_m}, 16'h0);
      chk("mid_rst_out", out_m, 16'h0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      for (int v = 31; v <= 34; v++) begin
         wr(16'(v));
         chk("post_rst_seq", {15'h0, seq_m}, 16'h0);
         chk("post_rst_full", {15'h0, full_m}, 16'h0);
         idle(9);
      end
      wr(16'd35);
      chk("post_rst_full_rise", {15'h0, full_m}, 16'h1);
      burst(5, 31);
      idle(2);

      // DEPTH=6, TAPS=6: non power-of-two wrap.
      sel = 1;
      for (int v = 1; v <= 9; v++) begin
         wr(16'(v));
         if (v >= 6) burst(6, v - 5);
         else chk("np2_seq", {15'h0, seq_m}, 16'h0);
         idle(3);
      end

      // TAPS=1: writes on three consecutive cycles, the middle one lands in SEQ.
      sel = 2;
      drive(1'b1, 16'd1);
      @(negedge clk);
      drive(1'b1, 16'd2);
      chk("b2b_t1_seq", {15'h0, seq_m}, 16'h1);
      chk("b2b_t1_vld", {15'h0, vld_m}, 16'h0);
      @(negedge clk);
      drive(1'b1, 16'd3);
      chk("b2b_t2_seq", {15'h0, seq_m}, 16'h0);
      chk("b2b_t2_vld", {15'h0, vld_m}, 16'h1);
      chk("b2b_t2_out", out_m, 16'd1);
      chk("b2b_t2_ovr", {15'h0, ovr_m}, {15'h0, ovr_exp});
      @(negedge clk);
      drive(1'b0, 16'h0);
      chk("b2b_t3_seq", {15'h0, seq_m}, 16'h1);
      chk("b2b_t3_vld", {15'h0, vld_m}, 16'h0);
      chk("b2b_t3_ovr", {15'h0, ovr_m}, 16'h0);
      @(negedge clk);
      chk("b2b_t4_vld", {15'h0, vld_m}, 16'h1);
      chk("b2b_t4_out", out_m, 16'd3);
      @(negedge clk);
      chk("b2b_t5_vld", {15'h0, vld_m}, 16'h0);
      idle(2);
      wr(16'd4);
      burst(1, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
